// File: rtl/seg7_scan_decoder.sv
// Recovers a 4-digit hex frame from a multiplexed active-low seven-segment bus.
// Optional glyph error counter is built when SEG7_DEC_ERRCNT_EN is defined.
module seg7_scan_decoder #(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [0:7]  seg,
    input  logic        digit1,
    input  logic        digit2,
    input  logic        digit3,
    input  logic        digit4,
    output logic [15:0] value,
    output logic [3:0]  dp,
    output logic [3:0]  blank,
    output logic        frame_valid,
    output logic        glyph_err,
    output logic        scan_err,
    output logic [7:0]  err_count,
    output logic [1:0]  dbg_state
);
    localparam int CW = $clog2(SETTLE);
    localparam int SW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, SETTLING = 2'd1, CAPTURED = 2'd2} state_t;

    // frame_valid and glyph_err are single-cycle strobes with no back-pressure:
    // a consumer must sample value/dp/blank in the cycle frame_valid is high.

    logic [0:7]    seg_m, seg_s, prev_seg;
    logic [3:0]    dig_m, dig_s;
    logic          sel, prev_sel;
    logic [1:0]    idx, prev_idx, pos;
    logic          changed, cap;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [SW-1:0] stall;
    logic [6:0]    pat;
    logic [3:0]    dec_nib;
    logic          dec_bad, dec_blank;
    logic [15:0]   nib_sh, nib_nx;
    logic [3:0]    dp_sh, dp_nx, blk_sh, blk_nx, seen, seen_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_m <= '1;
            seg_s <= '1;
            dig_m <= '1;
            dig_s <= '1;
        end else begin
            seg_m <= seg;
            seg_s <= seg_m;
            dig_m <= {digit1, digit2, digit3, digit4};
            dig_s <= dig_m;
        end
    end

    always_comb begin
        sel = 1'b1;
        idx = 2'd0;
        case (dig_s)
            4'b0111: idx = 2'd0;
            4'b1011: idx = 2'd1;
            4'b1101: idx = 2'd2;
            4'b1110: idx = 2'd3;
            default: sel = 1'b0;
        endcase
    end

    // Digit index 0 (digit1) lands in the most significant slot.
    assign pos     = ~idx;
    assign changed = {sel, idx, seg_s} != {prev_sel, prev_idx, prev_seg};
    assign cap     = (state == SETTLING) && sel && !changed && (cnt == CW'(SETTLE - 1));
    assign pat     = ~seg_s[0:6];

    always_comb begin
        dec_nib   = 4'h0;
        dec_bad   = 1'b0;
        dec_blank = 1'b0;
        case (pat)
            7'h7E: dec_nib = 4'h0;
            7'h30: dec_nib = 4'h1;
            7'h6D: dec_nib = 4'h2;
            7'h79: dec_nib = 4'h3;
            7'h33: dec_nib = 4'h4;
            7'h5B: dec_nib = 4'h5;
            7'h5F: dec_nib = 4'h6;
            7'h70: dec_nib = 4'h7;
            7'h7F: dec_nib = 4'h8;
            7'h7B: dec_nib = 4'h9;
            7'h77: dec_nib = 4'hA;
            7'h1F: dec_nib = 4'hB;
            7'h4E: dec_nib = 4'hC;
            7'h3D: dec_nib = 4'hD;
            7'h4F: dec_nib = 4'hE;
            7'h47: dec_nib = 4'hF;
            7'h00: dec_blank = 1'b1;
            default: dec_bad = 1'b1;
        endcase
    end

    // Shadow contents as they would be with the current capture merged in.
    always_comb begin
        nib_nx  = nib_sh;
        dp_nx   = dp_sh;
        blk_nx  = blk_sh;
        seen_nx = seen;
        nib_nx[{pos, 2'b00} +: 4] = dec_nib;
        dp_nx[pos]   = ~seg_s[7];
        blk_nx[pos]  = dec_blank;
        seen_nx[pos] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            prev_sel <= 1'b0;
            prev_idx <= 2'd0;
            prev_seg <= '1;
        end else begin
            prev_sel <= sel;
            prev_idx <= idx;
            prev_seg <= seg_s;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (sel) state <= SETTLING;
                end
                SETTLING: begin
                    if (!sel) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (changed) begin
                        cnt <= '0;
                    end else if (cap) begin
                        state <= CAPTURED;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CAPTURED: begin
                    cnt <= '0;
                    if (changed) state <= sel ? SETTLING : IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nib_sh      <= '0;
            dp_sh       <= '0;
            blk_sh      <= '0;
            seen        <= '0;
            value       <= '0;
            dp          <= '0;
            blank       <= 4'hF;
            frame_valid <= 1'b0;
            glyph_err   <= 1'b0;
            stall       <= '0;
        end else begin
            frame_valid <= 1'b0;
            glyph_err   <= cap && dec_bad;
            if (cap) begin
                stall  <= '0;
                nib_sh <= nib_nx;
                dp_sh  <= dp_nx;
                blk_sh <= blk_nx;
                if (seen_nx == 4'b1111) begin
                    value       <= nib_nx;
                    dp          <= dp_nx;
                    blank       <= blk_nx;
                    frame_valid <= 1'b1;
                    seen        <= '0;
                end else begin
                    seen <= seen_nx;
                end
            end else if (stall != SW'(TIMEOUT)) begin
                stall <= stall + 1'b1;
            end
        end
    end

    assign scan_err = (stall == SW'(TIMEOUT));

`ifdef SEG7_DEC_ERRCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (glyph_err && err_count != 8'hFF) begin
            err_count <= err_count + 1'b1;
        end
    end
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: drives scanned glyphs and checks committed frames.
module tb_seg7_scan_decoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [0:7]  seg_d = 8'hFF;
    logic [3:0]  dig = 4'hF;
    logic [15:0] value;
    logic [3:0]  dp, blank;
    logic        frame_valid, glyph_err, scan_err;
    logic [7:0]  err_count;
    logic [1:0]  dbg_state;

    int vectors = 0;
    int miscompares = 0;
    int fv_cnt = 0;
    int ge_cnt = 0;
    int fv_mark;

    localparam logic [6:0] G1 = 7'b0110000, G2 = 7'b1101101, G3 = 7'b1111001,
                           G4 = 7'b0110011, G5 = 7'b1011011, G6 = 7'b1011111,
                           G7 = 7'b1110000, G8 = 7'b1111111, G9 = 7'b1111011,
                           GA = 7'b1110111, GB = 7'b0011111, GC = 7'b1001110,
                           GD = 7'b0111101, GE = 7'b1001111, GAD = 7'b1001000,
                           GOFF = 7'b0000000;

`ifdef SEG7_DEC_ERRCNT_EN
    localparam logic [7:0] EXP_ERRCNT = 8'd1;
`else
    localparam logic [7:0] EXP_ERRCNT = 8'd0;
`endif

    seg7_scan_decoder #(.SETTLE(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .seg(seg_d),
        .digit1(dig[3]), .digit2(dig[2]), .digit3(dig[1]), .digit4(dig[0]),
        .value(value), .dp(dp), .blank(blank), .frame_valid(frame_valid),
        .glyph_err(glyph_err), .scan_err(scan_err), .err_count(err_count),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) fv_cnt++;
        if (glyph_err) ge_cnt++;
    end

    function automatic logic [7:0] enc(input logic [6:0] p, input logic d);
        return ~{p, d};
    endfunction

    // driver: digit d (0 = digit1, -1 = none) shows pattern s for n clocks
    task automatic drive(input int d, input logic [7:0] s, input int n);
        seg_d = s;
        dig = (d < 0) ? 4'hF : ~(4'b1000 >> d);
        repeat (n) @(negedge clk);
    endtask

    task automatic scan4(input logic [7:0] s1, input logic [7:0] s2,
                         input logic [7:0] s3, input logic [7:0] s4);
        drive(0, s1, 20);
        drive(1, s2, 20);
        drive(2, s3, 20);
        drive(3, s4, 20);
        drive(-1, 8'hFF, 6);
    endtask

    task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk16("reset value", value, 16'h0000);
        chk16("reset dp", {12'd0, dp}, 16'h0);
        chk16("reset blank", {12'd0, blank}, 16'hF);
        chk16("reset frame_valid", {15'd0, frame_valid}, 16'h0);
        chk16("reset glyph_err", {15'd0, glyph_err}, 16'h0);
        chk16("reset scan_err", {15'd0, scan_err}, 16'h0);
        chk16("reset err_count", {8'd0, err_count}, 16'h0);
    endtask

    task automatic test_scan_1234;
        fv_mark = fv_cnt;
        scan4(enc(G1, 0), enc(G2, 0), enc(G3, 0), enc(G4, 0));
        chk16("scan frames", 16'(fv_cnt - fv_mark), 16'd1);
        chk16("scan value", value, 16'h1234);
        chk16("scan blank", {12'd0, blank}, 16'h0);
        chk16("scan dp", {12'd0, dp}, 16'h0);
    endtask

    task automatic test_glitch;
        fv_mark = fv_cnt;
        drive(0, enc(G1, 0), 20);
        drive(1, enc(GA, 0), 10);
        drive(1, enc(G8, 0), 2);
        drive(1, enc(GA, 0), 3);
        drive(2, enc(G3, 0), 20);
        drive(3, enc(G4, 0), 20);
        drive(-1, 8'hFF, 6);
        chk16("glitch frames", 16'(fv_cnt - fv_mark), 16'd1);
        chk16("glitch value", value, 16'h1A34);
    endtask

    task automatic test_bad_glyph;
        fv_mark = fv_cnt;
        scan4(enc(G5, 0), enc(G6, 0), enc(GAD, 0), enc(G7, 0));
        chk16("bad glyph pulses", 16'(ge_cnt), 16'd1);
        chk16("bad err_count", {8'd0, err_count}, {8'd0, EXP_ERRCNT});
        chk16("bad value", value, 16'h5607);
        chk16("bad blank", {12'd0, blank}, 16'h0);
    endtask

    task automatic test_blank_dp;
        scan4(enc(GC, 0), enc(GD, 0), enc(GE, 0), enc(GOFF, 1));
        chk16("blank value", value, 16'hCDE0);
        chk16("blank blank", {12'd0, blank}, 16'h1);
        chk16("blank dp", {12'd0, dp}, 16'h1);
        chk16("blank frame_valid", 16'(fv_cnt - fv_mark), 16'd2);
    endtask

    task automatic test_stall;
        repeat (30) @(negedge clk);
        chk16("stall early", {15'd0, scan_err}, 16'h0);
        repeat (30) @(negedge clk);
        chk16("stall expired", {15'd0, scan_err}, 16'h1);
        drive(0, enc(G1, 0), 20);
        chk16("stall cleared", {15'd0, scan_err}, 16'h0);
        drive(-1, 8'hFF, 6);
    endtask

    task automatic test_reset_mid_frame;
        drive(0, enc(G9, 0), 20);
        drive(1, enc(G8, 0), 20);
        drive(2, enc(G7, 0), 20);
        drive(-1, 8'hFF, 4);
        rst = 1'b1;
        #1;
        chk16("rst mid value", value, 16'h0000);
        chk16("rst mid blank", {12'd0, blank}, 16'hF);
        chk16("rst mid dp", {12'd0, dp}, 16'h0);
        chk16("rst mid err_count", {8'd0, err_count}, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        fv_mark = fv_cnt;
        drive(3, enc(G6, 0), 20);
        drive(-1, 8'hFF, 6);
        chk16("rst mid no frame 1", 16'(fv_cnt - fv_mark), 16'd0);
        drive(0, enc(G1, 0), 20);
        drive(1, enc(G2, 0), 20);
        drive(-1, 8'hFF, 6);
        chk16("rst mid no frame 3", 16'(fv_cnt - fv_mark), 16'd0);
        drive(2, enc(G3, 0), 20);
        drive(-1, 8'hFF, 6);
        chk16("rst mid frame", 16'(fv_cnt - fv_mark), 16'd1);
        chk16("rst mid new value", value, 16'h1236);
    endtask

    initial begin
        test_reset();
        test_scan_1234();
        test_glitch();
        test_bad_glyph();
        test_blank_dp();
        test_stall();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
